// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-fetch request bus between the PC/fetch controller
// and the instruction memory side: valid/ready style request.
interface pc_fetch_ctrl_if #(
  parameter int PC_W = 32
) ();
  logic            inst_req;
  logic [PC_W-1:0] inst_addr;
  logic            inst_addr_ok;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage next-PC controller: MIPS branch/jump resolution with
// one delay slot, pending-redirect capture and flush priority.
module pc_fetch_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'hbfc00000,
  parameter logic [PC_W-1:0] EXC_PC   = 32'hbfc00380,
  parameter int              LINK_OFS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_pc,
  input  logic            is_b,
  input  logic            is_j,
  input  logic            is_jr,
  input  logic [3:0]      b_type,
  input  logic [15:0]     b_offset,
  input  logic [25:0]     j_index,
  input  logic [PC_W-1:0] rdata1,
  input  logic [PC_W-1:0] rdata2,
  input  logic            exc_valid,
  input  logic            eret_valid,
  input  logic [PC_W-1:0] epc,
  pc_fetch_ctrl_if.master fetch,
  output logic            br_taken,
  output logic [PC_W-1:0] link_addr,
  output logic            fetch_adel
);

  typedef enum logic {
    NORMAL,
    PENDING
  } state_t;

  localparam logic [PC_W-1:0] FOUR = PC_W'(4);

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pend_tgt;
  logic            req_hold;
  logic            adel_seen;

  logic            flush;
  logic            misal;
  logic            accept;
  logic            cond;
  logic            rs_neg;
  logic            rs_zero;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] b_tgt;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] tgt;

  assign flush   = exc_valid | eret_valid;
  assign misal   = pc_q[1:0] != 2'b00;
  assign rs_neg  = rdata1[PC_W-1];
  assign rs_zero = rdata1 == '0;

  assign fetch.inst_addr = pc_q;
  assign fetch.inst_req  = !reset && !flush && !misal
                        && (req_hold || !stall);
  assign accept = fetch.inst_req & fetch.inst_addr_ok;

  // Raised once on entering a misaligned PC; held off until flush.
  assign fetch_adel = !reset && !flush && misal && !adel_seen;

  always_comb begin
    cond = 1'b0;
    case (b_type)
      4'd0:    cond = rdata1 != rdata2;
      4'd1:    cond = rdata1 == rdata2;
      4'd2:    cond = !rs_neg;
      4'd3:    cond = !rs_neg && !rs_zero;
      4'd4:    cond = rs_neg || rs_zero;
      4'd5:    cond = rs_neg;
      default: cond = 1'b0;
    endcase
  end

  assign seq_pc = br_pc + FOUR;
  assign b_tgt  = seq_pc
                + {{(PC_W-18){b_offset[15]}}, b_offset, 2'b00};
  assign j_tgt  = {seq_pc[PC_W-1:28], j_index, 2'b00};

  always_comb begin
    tgt = b_tgt;
    priority case (1'b1)
      is_jr:   tgt = rdata1;
      is_j:    tgt = j_tgt;
      default: tgt = b_tgt;
    endcase
  end

  assign br_taken  = br_valid && ((is_b && cond) || is_j || is_jr);
  assign link_addr = br_pc + PC_W'(LINK_OFS);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      state     <= NORMAL;
      pend_tgt  <= '0;
      req_hold  <= 1'b0;
      adel_seen <= 1'b0;
    end else if (exc_valid) begin
      pc_q      <= EXC_PC;
      state     <= NORMAL;
      req_hold  <= 1'b0;
      adel_seen <= 1'b0;
    end else if (eret_valid) begin
      pc_q      <= epc;
      state     <= NORMAL;
      req_hold  <= 1'b0;
      adel_seen <= 1'b0;
    end else begin
      req_hold <= fetch.inst_req & !fetch.inst_addr_ok;
      if (fetch_adel) adel_seen <= 1'b1;
      // The delay slot sits in pc_q; a redirect lands only once it is taken.
      if (accept && br_taken) begin
        pc_q  <= tgt;
        state <= NORMAL;
      end else if (accept && state == PENDING) begin
        pc_q  <= pend_tgt;
        state <= NORMAL;
      end else if (accept) begin
        pc_q <= pc_q + FOUR;
      end else if (br_taken) begin
        pend_tgt <= tgt;
        state    <= PENDING;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: expected fetch addresses are
// queued by the stimulus and popped by a monitor on every accept.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_pc;
  logic        is_b;
  logic        is_j;
  logic        is_jr;
  logic [3:0]  b_type;
  logic [15:0] b_offset;
  logic [25:0] j_index;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic        br_taken;
  logic [31:0] link_addr;
  logic        fetch_adel;

  pc_fetch_ctrl_if #(.PC_W(32)) f ();

  pc_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_pc      (br_pc),
    .is_b       (is_b),
    .is_j       (is_j),
    .is_jr      (is_jr),
    .b_type     (b_type),
    .b_offset   (b_offset),
    .j_index    (j_index),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .exc_valid  (exc_valid),
    .eret_valid (eret_valid),
    .epc        (epc),
    .fetch      (f),
    .br_taken   (br_taken),
    .link_addr  (link_addr),
    .fetch_adel (fetch_adel)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] adel_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_br();
    br_valid = 0; is_b = 0; is_j = 0; is_jr = 0;
    b_type = 0; b_offset = 0; j_index = 0;
    rdata1 = 0; rdata2 = 0; br_pc = 0;
  endtask

  task automatic set_b(input logic [3:0] t, input logic [31:0] pc,
                       input logic [15:0] ofs, input logic [31:0] rs,
                       input logic [31:0] rt);
    clr_br();
    br_valid = 1; is_b = 1; b_type = t;
    br_pc = pc; b_offset = ofs; rdata1 = rs; rdata2 = rt;
  endtask

  // Monitor: every accepted fetch and every address-error pulse
  always @(negedge clk) begin
    if (f.inst_req && f.inst_addr_ok) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fetch_unexpected: got %h expected none",
                 f.inst_addr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (f.inst_addr !== e) begin
          n_fail++;
          $display("FAIL fetch_addr: got %h expected %h", f.inst_addr, e);
        end
      end
    end
    if (fetch_adel) begin
      n_chk++;
      if (adel_q.size() == 0) begin
        n_fail++;
        $display("FAIL adel_unexpected: got %h expected none",
                 f.inst_addr);
      end else begin
        logic [31:0] e;
        e = adel_q.pop_front();
        if (f.inst_addr !== e) begin
          n_fail++;
          $display("FAIL adel_addr: got %h expected %h", f.inst_addr, e);
        end
      end
    end
  end

  initial begin
    reset = 1; stall = 0; exc_valid = 0; eret_valid = 0; epc = 0;
    f.inst_addr_ok = 1;
    clr_br();
    #1;
    chk("reset_req0", {31'b0, f.inst_req}, 0);
    chk("reset_adel0", {31'b0, fetch_adel}, 0);
    cyc();
    chk("reset_req1", {31'b0, f.inst_req}, 0);
    chk("reset_pc", f.inst_addr, 32'hbfc00000);

    // sequential fetch
    exp_q.push_back(32'hbfc00000);
    exp_q.push_back(32'hbfc00004);
    exp_q.push_back(32'hbfc00008);
    reset = 0;
    cyc(); cyc(); cyc();

    // BEQ taken, accepted in the same cycle
    set_b(4'd1, 32'hbfc00010, 16'hfffc, 32'd5, 32'd5);
    exp_q.push_back(32'hbfc0000c);
    exp_q.push_back(32'hbfc00004);
    #1;
    chk("beq_taken", {31'b0, br_taken}, 1);
    chk("beq_link", link_addr, 32'hbfc00018);
    cyc();
    clr_br();
    cyc();

    // BNE taken while the fetch is not accepted
    f.inst_addr_ok = 0;
    set_b(4'd0, 32'hbfc00020, 16'h0010, 32'd1, 32'd2);
    #1;
    chk("bne_taken", {31'b0, br_taken}, 1);
    chk("bne_req", {31'b0, f.inst_req}, 1);
    cyc();
    clr_br();
    stall = 1;
    #1;
    chk("hold_req1", {31'b0, f.inst_req}, 1);
    chk("hold_addr1", f.inst_addr, 32'hbfc00008);
    cyc();
    chk("hold_req2", {31'b0, f.inst_req}, 1);
    chk("hold_addr2", f.inst_addr, 32'hbfc00008);
    f.inst_addr_ok = 1;
    exp_q.push_back(32'hbfc00008);
    exp_q.push_back(32'hbfc00064);
    cyc();
    stall = 0;
    cyc();

    // BGTZ rs=0 not taken
    set_b(4'd3, 32'hbfc00064, 16'h0040, 32'd0, 32'd0);
    exp_q.push_back(32'hbfc00068);
    #1;
    chk("bgtz_nt", {31'b0, br_taken}, 0);
    cyc();
    // BLTZ rs=80000000 taken
    set_b(4'd5, 32'hbfc00068, 16'h0002, 32'h80000000, 32'd0);
    exp_q.push_back(32'hbfc0006c);
    #1;
    chk("bltz_t", {31'b0, br_taken}, 1);
    cyc();
    // BLEZ rs=0 taken
    set_b(4'd4, 32'hbfc00070, 16'h0004, 32'd0, 32'd0);
    exp_q.push_back(32'hbfc00074);
    #1;
    chk("blez_t", {31'b0, br_taken}, 1);
    cyc();

    // JR with a simultaneous BEQ: jr wins, target misaligned
    set_b(4'd1, 32'hbfc00080, 16'h0100, 32'hbfc00102, 32'hbfc00102);
    is_jr = 1;
    exp_q.push_back(32'hbfc00084);
    adel_q.push_back(32'hbfc00102);
    #1;
    chk("jr_taken", {31'b0, br_taken}, 1);
    cyc();
    clr_br();
    #1;
    chk("adel_pulse", {31'b0, fetch_adel}, 1);
    chk("adel_req0", {31'b0, f.inst_req}, 0);
    chk("adel_addr", f.inst_addr, 32'hbfc00102);
    cyc();
    chk("adel_once", {31'b0, fetch_adel}, 0);
    chk("adel_hold", f.inst_addr, 32'hbfc00102);
    exc_valid = 1;
    #1;
    chk("exc_req0", {31'b0, f.inst_req}, 0);
    exp_q.push_back(32'hbfc00380);
    cyc();
    exc_valid = 0;
    cyc();

    // J pending, then exception discards the pending redirect
    f.inst_addr_ok = 0;
    clr_br();
    br_valid = 1; is_j = 1; br_pc = 32'hbfc00384;
    j_index = 26'h3f00100;
    #1;
    chk("j_taken", {31'b0, br_taken}, 1);
    cyc();
    clr_br();
    f.inst_addr_ok = 1;
    exc_valid = 1;
    #1;
    chk("exc_pend_req0", {31'b0, f.inst_req}, 0);
    exp_q.push_back(32'hbfc00380);
    exp_q.push_back(32'hbfc00384);
    cyc();
    exc_valid = 0;
    cyc(); cyc();

    // ERET
    eret_valid = 1; epc = 32'hbfc00040;
    #1;
    chk("eret_req0", {31'b0, f.inst_req}, 0);
    exp_q.push_back(32'hbfc00040);
    cyc();
    eret_valid = 0;
    cyc();

    // Two redirects while blocked: the latest wins
    f.inst_addr_ok = 0;
    set_b(4'd1, 32'hbfc00040, 16'h0010, 32'd0, 32'd0);
    cyc();
    set_b(4'd0, 32'hbfc00040, 16'h0020, 32'd1, 32'd0);
    cyc();
    clr_br();
    f.inst_addr_ok = 1;
    exp_q.push_back(32'hbfc00044);
    exp_q.push_back(32'hbfc000c4);
    cyc(); cyc();

    // Reset mid-operation abandons an outstanding request
    f.inst_addr_ok = 0;
    cyc();
    reset = 1;
    #1;
    chk("midreset_req0", {31'b0, f.inst_req}, 0);
    cyc();
    reset = 0;
    f.inst_addr_ok = 1;
    exp_q.push_back(32'hbfc00000);
    cyc();
    f.inst_addr_ok = 0;
    cyc(); cyc();

    chk("exp_q_drained", exp_q.size(), 0);
    chk("adel_q_drained", adel_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
